scanline_sequencer: RTL and testbench



---
 rtl/scanline_sequencer_if.sv | 35 +++
 rtl/scanline_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_scanline_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scanline_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : scanline_sequencer_if                                          |
// | Brief   : Sequencer <-> delay array / transmit front-end handshake bus   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface scanline_sequencer_if #(
  parameter int DW_INPUT = 8,
  parameter int DW_ANGLE = 8
);
  logic [DW_INPUT-1:0] r_0;
  logic [DW_ANGLE-1:0] angle;
  logic                configure;
  logic                ack;
  logic                final_scanpoint;
  logic                transmit_done;
  logic                arr_done_configuring;
  logic                arr_ready;
  logic                seed_sel;
  logic                tx_start;
  logic                tx_done;

  modport master (
    output r_0, angle, configure, ack, final_scanpoint, transmit_done,
           seed_sel, tx_start,
    input  arr_done_configuring, arr_ready, tx_done
  );

  modport slave (
    input  r_0, angle, configure, ack, final_scanpoint, transmit_done,
           seed_sel, tx_start,
    output arr_done_configuring, arr_ready, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/scanline_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : scanline_sequencer                                             |
// | Brief   : Steps the delay array through scanlines/scanpoints of a frame  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module scanline_sequencer #(
  parameter int DW_INPUT  = 8,
  parameter int DW_ANGLE  = 8,
  parameter int DW_PT_CNT = 10,
  parameter int DW_LN_CNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DW_INPUT-1:0]  r_0_cfg,
  input  logic [DW_ANGLE-1:0]  angle_start,
  input  logic [DW_ANGLE-1:0]  angle_step,
  input  logic [DW_LN_CNT-1:0] num_lines,
  input  logic [DW_PT_CNT-1:0] num_points,
  scanline_sequencer_if.master arr,
  output logic [DW_LN_CNT-1:0] line_idx,
  output logic [DW_PT_CNT-1:0] point_idx,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CONFIG   = 4'd1,
    S_WAIT_CFG = 4'd2,
    S_KICK     = 4'd3,
    S_WAIT_RDY = 4'd4,
    S_TX       = 4'd5,
    S_WAIT_TX  = 4'd6,
    S_ADV      = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [DW_INPUT-1:0]  r_0_q, r_0_d;
  logic [DW_ANGLE-1:0]  angle_q, angle_d;
  logic [DW_ANGLE-1:0]  angle_step_q, angle_step_d;
  logic [DW_LN_CNT-1:0] num_lines_q, num_lines_d;
  logic [DW_PT_CNT-1:0] num_points_q, num_points_d;
  logic [DW_LN_CNT-1:0] line_idx_q, line_idx_d;
  logic [DW_PT_CNT-1:0] point_idx_q, point_idx_d;
  logic                 configure_q, configure_d;
  logic                 ack_q, ack_d;
  logic                 final_q, final_d;
  logic                 transmit_done_q, transmit_done_d;
  logic                 tx_start_q, tx_start_d;
  logic                 seed_sel_q, seed_sel_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 tx_pend_q, tx_pend_d;
  logic                 last_point, last_line;

  assign last_point = (point_idx_q == num_points_q - DW_PT_CNT'(1));
  assign last_line  = (line_idx_q == num_lines_q - DW_LN_CNT'(1));

  always_comb begin
    state_d         = state_q;
    r_0_d           = r_0_q;
    angle_d         = angle_q;
    angle_step_d    = angle_step_q;
    num_lines_d     = num_lines_q;
    num_points_d    = num_points_q;
    line_idx_d      = line_idx_q;
    point_idx_d     = point_idx_q;
    seed_sel_d      = seed_sel_q;
    tx_pend_d       = tx_pend_q;
    configure_d     = 1'b0;
    ack_d           = 1'b0;
    final_d         = 1'b0;
    transmit_done_d = 1'b0;
    tx_start_d      = 1'b0;
    frame_done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_lines_d  = num_lines;
          num_points_d = num_points;
          angle_step_d = angle_step;
          line_idx_d   = '0;
          point_idx_d  = '0;
          seed_sel_d   = 1'b1;
          if (num_lines == '0 || num_points == '0) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            r_0_d       = r_0_cfg;
            angle_d     = angle_start;
            configure_d = 1'b1;
            state_d     = S_CONFIG;
          end
        end
      end
      // Entered from ADV the final ack is still on the bus, so configure
      // is held back one cycle to keep configure and ack disjoint.
      S_CONFIG: begin
        if (configure_q) begin
          state_d = S_WAIT_CFG;
        end else begin
          configure_d = 1'b1;
        end
      end
      S_WAIT_CFG: begin
        if (arr.arr_done_configuring) begin
          ack_d   = 1'b1;
          state_d = S_KICK;
        end
      end
      S_KICK: begin
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        tx_pend_d = 1'b0;
        if (arr.arr_ready) begin
          tx_start_d = 1'b1;
          state_d    = S_TX;
        end
      end
      S_TX: begin
        tx_pend_d = arr.tx_done;
        state_d   = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (arr.tx_done || tx_pend_q) begin
          tx_pend_d       = 1'b0;
          transmit_done_d = 1'b1;
          state_d         = S_ADV;
        end
      end
      S_ADV: begin
        ack_d = 1'b1;
        if (last_point) begin
          final_d     = 1'b1;
          point_idx_d = '0;
          seed_sel_d  = 1'b1;
          if (last_line) begin
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            line_idx_d = line_idx_q + DW_LN_CNT'(1);
            angle_d    = angle_q + angle_step_q;
            state_d    = S_CONFIG;
          end
        end else begin
          point_idx_d = point_idx_q + DW_PT_CNT'(1);
          seed_sel_d  = 1'b0;
          state_d     = S_WAIT_RDY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q         <= S_IDLE;
      r_0_q           <= '0;
      angle_q         <= '0;
      angle_step_q    <= '0;
      num_lines_q     <= '0;
      num_points_q    <= '0;
      line_idx_q      <= '0;
      point_idx_q     <= '0;
      configure_q     <= 1'b0;
      ack_q           <= 1'b0;
      final_q         <= 1'b0;
      transmit_done_q <= 1'b0;
      tx_start_q      <= 1'b0;
      seed_sel_q      <= 1'b1;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      tx_pend_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      r_0_q           <= r_0_d;
      angle_q         <= angle_d;
      angle_step_q    <= angle_step_d;
      num_lines_q     <= num_lines_d;
      num_points_q    <= num_points_d;
      line_idx_q      <= line_idx_d;
      point_idx_q     <= point_idx_d;
      configure_q     <= configure_d;
      ack_q           <= ack_d;
      final_q         <= final_d;
      transmit_done_q <= transmit_done_d;
      tx_start_q      <= tx_start_d;
      seed_sel_q      <= seed_sel_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      tx_pend_q       <= tx_pend_d;
    end
  end

  assign arr.r_0             = r_0_q;
  assign arr.angle           = angle_q;
  assign arr.configure       = configure_q;
  assign arr.ack             = ack_q;
  assign arr.final_scanpoint = final_q;
  assign arr.transmit_done   = transmit_done_q;
  assign arr.tx_start        = tx_start_q;
  assign arr.seed_sel        = seed_sel_q;
  assign line_idx            = line_idx_q;
  assign point_idx           = point_idx_q;
  assign busy                = busy_q;
  assign frame_done          = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_scanline_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_scanline_sequencer                                          |
// | Brief   : Directed bench with an array/transmitter responder model       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_scanline_sequencer;
  localparam int DW_INPUT  = 8;
  localparam int DW_ANGLE  = 8;
  localparam int DW_PT_CNT = 10;
  localparam int DW_LN_CNT = 8;

  logic                 clk = 1'b0;
  logic                 rst, start, abort;
  logic [DW_INPUT-1:0]  r_0_cfg;
  logic [DW_ANGLE-1:0]  angle_start, angle_step;
  logic [DW_LN_CNT-1:0] num_lines;
  logic [DW_PT_CNT-1:0] num_points;
  logic [DW_LN_CNT-1:0] line_idx;
  logic [DW_PT_CNT-1:0] point_idx;
  logic                 busy, frame_done;

  scanline_sequencer_if #(.DW_INPUT(DW_INPUT), .DW_ANGLE(DW_ANGLE)) bus ();

  scanline_sequencer #(
    .DW_INPUT(DW_INPUT), .DW_ANGLE(DW_ANGLE),
    .DW_PT_CNT(DW_PT_CNT), .DW_LN_CNT(DW_LN_CNT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .r_0_cfg(r_0_cfg), .angle_start(angle_start), .angle_step(angle_step),
    .num_lines(num_lines), .num_points(num_points), .arr(bus),
    .line_idx(line_idx), .point_idx(point_idx), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_cfg, n_ack, n_final, n_txs, n_tdone, n_fd, n_busy, n_seed1, viol;
  logic [7:0] cfg_angle [4];
  logic [7:0] cfg_line  [4];
  logic [7:0] cfg_r0    [4];
  int cfg_dly = 1, rdy_dly = 1, tx_dly = 0;
  int cfg_cnt = 0, rdy_cnt = 0, tx_cnt = 0;
  logic in_tx = 1'b0;
  logic p_cfg = 1'b0, p_ack = 1'b0, p_txs = 1'b0, p_td = 1'b0, p_fd = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_cfg = 0; n_ack = 0; n_final = 0; n_txs = 0; n_tdone = 0;
    n_fd = 0; n_busy = 0; n_seed1 = 0; viol = 0; in_tx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_angle[i] = 8'hxx; cfg_line[i] = 8'hxx; cfg_r0[i] = 8'hxx;
    end
  endtask

  task automatic do_start(input int lines, input int points, input int a0,
                          input int step, input int r0);
    @(negedge clk);
    clear_counts();
    num_lines   = DW_LN_CNT'(lines);
    num_points  = DW_PT_CNT'(points);
    angle_start = DW_ANGLE'(a0);
    angle_step  = DW_ANGLE'(step);
    r_0_cfg     = DW_INPUT'(r0);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int max_cyc);
    logic got;
    got = 1'b0;
    for (int k = 0; k < max_cyc && !got; k++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    check(tag, 32'(got), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulses"}, 32'({bus.configure, bus.ack, bus.final_scanpoint,
          bus.transmit_done, bus.tx_start, frame_done}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_seed"}, 32'(bus.seed_sel), 32'd1);
    check({tag, "_r0_angle"}, 32'({bus.r_0, bus.angle}), 32'd0);
    check({tag, "_idx"}, 32'({line_idx, point_idx}), 32'd0);
  endtask

  // Responder for the array and transmitter, plus protocol monitor.
  initial begin
    bus.arr_done_configuring = 1'b0;
    bus.arr_ready            = 1'b0;
    bus.tx_done              = 1'b0;
    forever begin
      @(negedge clk);
      bus.arr_done_configuring = 1'b0;
      bus.arr_ready            = 1'b0;
      bus.tx_done              = 1'b0;
      if (cfg_cnt > 0) begin cfg_cnt--; if (cfg_cnt == 0) bus.arr_done_configuring = 1'b1; end
      if (rdy_cnt > 0) begin rdy_cnt--; if (rdy_cnt == 0) bus.arr_ready = 1'b1; end
      if (tx_cnt > 0)  begin tx_cnt--;  if (tx_cnt == 0)  bus.tx_done = 1'b1; end
      if (bus.configure) begin cfg_cnt = cfg_dly; rdy_cnt = 0; end
      if (bus.ack && !bus.final_scanpoint) rdy_cnt = rdy_dly;
      if (bus.tx_start) begin
        if (tx_dly == 0) bus.tx_done = 1'b1;
        else tx_cnt = tx_dly;
      end

      if (bus.configure) begin
        if (n_cfg < 4) begin
          cfg_angle[n_cfg] = bus.angle;
          cfg_line[n_cfg]  = line_idx;
          cfg_r0[n_cfg]    = bus.r_0;
        end
        n_cfg++;
      end
      if (bus.ack) n_ack++;
      if (bus.final_scanpoint) n_final++;
      if (bus.transmit_done) begin n_tdone++; in_tx = 1'b0; end
      if (bus.tx_start) begin
        n_txs++;
        in_tx = 1'b1;
        if (bus.seed_sel) n_seed1++;
        if (bus.seed_sel !== (point_idx == '0)) viol++;
      end
      if (frame_done) n_fd++;
      if (busy) n_busy++;
      if (bus.configure && bus.ack) viol++;
      if (bus.final_scanpoint && !bus.ack) viol++;
      if (bus.ack && in_tx) viol++;
      if ((bus.configure && p_cfg) || (bus.ack && p_ack) || (bus.tx_start && p_txs) ||
          (bus.transmit_done && p_td) || (frame_done && p_fd)) viol++;
      p_cfg = bus.configure; p_ack = bus.ack; p_txs = bus.tx_start;
      p_td  = bus.transmit_done; p_fd = frame_done;
    end
  end

  initial begin
    logic got;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    r_0_cfg = '0; angle_start = '0; angle_step = '0; num_lines = '0; num_points = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic 2x3 frame with immediate tx_done
    tx_dly = 0; rdy_dly = 1; cfg_dly = 1;
    do_start(2, 3, 10, 5, 40);
    check("start_to_configure", 32'(bus.configure), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    check("r0_angle_latched", 32'({bus.r_0, bus.angle}), {16'd0, 8'd40, 8'd10});
    wait_frame("frameA_timeout", 400);
    check("frameA_cfg", 32'(n_cfg), 32'd2);
    check("frameA_angles", {16'd0, cfg_angle[0], cfg_angle[1]}, {16'd0, 8'd10, 8'd15});
    check("frameA_lines_r0", {cfg_line[0], cfg_line[1], cfg_r0[0], cfg_r0[1]},
          {8'd0, 8'd1, 8'd40, 8'd40});
    check("frameA_txs", 32'(n_txs), 32'd6);
    check("frameA_tdone", 32'(n_tdone), 32'd6);
    check("frameA_final", 32'(n_final), 32'd2);
    check("frameA_ack", 32'(n_ack), 32'd8);
    check("frameA_fd", 32'(n_fd), 32'd1);
    check("frameA_viol", 32'(viol), 32'd0);
    check("frameA_idle_busy", 32'(busy), 32'd0);

    // Angle wrap
    do_start(2, 1, 250, 10, 7);
    wait_frame("wrap_timeout", 200);
    check("wrap_angles", {16'd0, cfg_angle[0], cfg_angle[1]}, {16'd0, 8'd250, 8'd4});
    check("wrap_ack", 32'(n_ack), 32'd4);
    check("wrap_final", 32'(n_final), 32'd2);
    check("wrap_viol", 32'(viol), 32'd0);

    // Empty frame
    do_start(3, 0, 1, 1, 1);
    check("empty_fd_latency", 32'(frame_done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("empty_cfg_ack", 32'(n_cfg + n_ack), 32'd0);
    check("empty_busy_never", 32'(n_busy), 32'd0);
    check("empty_fd_count", 32'(n_fd), 32'd1);

    // Slow transmitter and array
    tx_dly = 20; rdy_dly = 7;
    do_start(2, 3, 30, 2, 9);
    wait_frame("slow_timeout", 1000);
    check("slow_txs", 32'(n_txs), 32'd6);
    check("slow_ack", 32'(n_ack), 32'd8);
    check("slow_seed1", 32'(n_seed1), 32'd2);
    check("slow_viol", 32'(viol), 32'd0);
    check("slow_fd", 32'(n_fd), 32'd1);

    // Abort in WAIT_TX of point 1
    tx_dly = 20; rdy_dly = 1;
    do_start(2, 3, 10, 5, 40);
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge clk);
      if (bus.tx_start && point_idx == 10'd1) got = 1'b1;
    end
    check("abort_reach_pt1", 32'(got), 32'd1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_reset_outputs("abort");
    repeat (30) @(negedge clk);
    check("abort_no_fd_final", 32'(n_fd + n_final), 32'd0);
    tx_dly = 0;
    do_start(1, 2, 20, 0, 3);
    wait_frame("after_abort_timeout", 200);
    check("after_abort_counts", {8'(n_cfg), 8'(n_txs), 8'(n_ack), 8'(n_final)},
          {8'd1, 8'd2, 8'd3, 8'd1});
    check("after_abort_angle", 32'(cfg_angle[0]), 32'd20);

    // start while busy is ignored
    tx_dly = 5;
    do_start(1, 2, 10, 0, 5);
    repeat (4) @(negedge clk);
    num_points = 10'd7; angle_start = 8'd99; num_lines = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_frame("busy_start_timeout", 300);
    check("busy_start_counts", {8'(n_cfg), 8'(n_txs), 8'(n_fd), 8'(viol)},
          {8'd1, 8'd2, 8'd1, 8'd0});
    check("busy_start_angle", 32'(cfg_angle[0]), 32'd10);

    // rst in WAIT_RDY
    tx_dly = 0; rdy_dly = 7;
    do_start(2, 2, 60, 3, 11);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.ack) got = 1'b1;
    end
    check("rst_reach_kick", 32'(got), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_wait_rdy");
    repeat (10) @(negedge clk);
    check("rst_no_tx", 32'(n_txs + n_fd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "global timeout");
  end
endmodule
`default_nettype wire
